// File: rtl/sort_step_sequencer.sv
// sort_step_sequencer
//   Controller for the 16-entry windowed sorter. On a request it issues a
//   load strobe, then ROUNDS pairs of odd/even 4-wide window phases (with
//   GAP_CYCLES idle cycles after each phase), then the finish code. It then
//   waits up to TIMEOUT cycles for sort_done and returns a one-cycle done
//   pulse. The done pulse carries err if the wait timed out.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req        in   start a sort; sampled only while idle
//   sort_done  in   sorter done_sorting; only honoured while waiting
//   start      out  load strobe to the sorter
//   seq_no     out  [3:0] window base offset
//   state      out  [2:0] step code: 000 idle/gap, 001 phase A, 010 phase B, 101 finish
//   busy       out  high from load through done inclusive
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse with done on timeout
//   round      out  [2:0] current round index (debug)
//
// All outputs are registered: the next-state logic also produces the output
// values for the state being entered, and both are captured on the same edge.
module sort_step_sequencer #(
    parameter int ROUNDS     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       sort_done,
    output logic       start,
    output logic [3:0] seq_no,
    output logic [2:0] state,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] round
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_PH_A, S_GAP_A, S_PH_B, S_GAP_B, S_FIN, S_WAIT, S_DONE
    } fsm_t;

    localparam logic [7:0] LAST_A   = 8'd3;
    localparam logic [7:0] LAST_B   = 8'd2;
    localparam logic [7:0] LAST_GAP = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] LAST_TO  = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_RND = 3'(ROUNDS - 1);

    fsm_t       r_fsm, w_nxt_fsm;
    logic [7:0] r_cnt, w_nxt_cnt;
    logic [2:0] w_nxt_round;
    logic       w_nxt_err;
    logic       w_nxt_start;
    logic [3:0] w_nxt_seq;
    logic [2:0] w_nxt_state;

    // Next-state logic. r_cnt is shared: window index in the phases, gap
    // cycle count in the gaps, and elapsed wait cycles in WAIT.
    always_comb begin
        w_nxt_fsm   = r_fsm;
        w_nxt_cnt   = r_cnt;
        w_nxt_round = round;
        w_nxt_err   = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                w_nxt_round = '0;
                w_nxt_cnt   = '0;
                if (req) w_nxt_fsm = S_LOAD;
            end
            S_LOAD: begin
                w_nxt_fsm = S_PH_A;
                w_nxt_cnt = '0;
            end
            S_PH_A: begin
                if (r_cnt == LAST_A) begin
                    w_nxt_fsm = S_GAP_A;
                    w_nxt_cnt = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_GAP_A: begin
                if (r_cnt == LAST_GAP) begin
                    w_nxt_fsm = S_PH_B;
                    w_nxt_cnt = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_PH_B: begin
                if (r_cnt == LAST_B) begin
                    w_nxt_fsm = S_GAP_B;
                    w_nxt_cnt = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_GAP_B: begin
                if (r_cnt == LAST_GAP) begin
                    w_nxt_cnt = '0;
                    if (round == LAST_RND) begin
                        w_nxt_fsm = S_FIN;
                    end else begin
                        w_nxt_fsm   = S_PH_A;
                        w_nxt_round = round + 3'd1;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_FIN: begin
                w_nxt_fsm = S_WAIT;
                w_nxt_cnt = '0;
            end
            S_WAIT: begin
                // sort_done wins over a simultaneous timeout.
                if (sort_done) begin
                    w_nxt_fsm = S_DONE;
                end else if (r_cnt == LAST_TO) begin
                    w_nxt_fsm = S_DONE;
                    w_nxt_err = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_nxt_fsm   = S_IDLE;
                w_nxt_round = '0;
                w_nxt_cnt   = '0;
            end
            default: w_nxt_fsm = S_IDLE;
        endcase
    end

    // Output values for the state being entered.
    always_comb begin
        w_nxt_start = 1'b0;
        w_nxt_seq   = '0;
        w_nxt_state = 3'b000;
        unique case (w_nxt_fsm)
            S_LOAD:  w_nxt_start = 1'b1;
            S_PH_A: begin
                w_nxt_state = 3'b001;
                w_nxt_seq   = {w_nxt_cnt[1:0], 2'b00};
            end
            S_PH_B: begin
                w_nxt_state = 3'b010;
                w_nxt_seq   = {w_nxt_cnt[1:0], 2'b10};
            end
            S_GAP_A, S_GAP_B: w_nxt_seq = seq_no;
            S_FIN:   w_nxt_state = 3'b101;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm  <= S_IDLE;
            r_cnt  <= '0;
            start  <= 1'b0;
            seq_no <= '0;
            state  <= 3'b000;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            round  <= '0;
        end else begin
            r_fsm  <= w_nxt_fsm;
            r_cnt  <= w_nxt_cnt;
            start  <= w_nxt_start;
            seq_no <= w_nxt_seq;
            state  <= w_nxt_state;
            busy   <= (w_nxt_fsm != S_IDLE);
            done   <= (w_nxt_fsm == S_DONE);
            err    <= (w_nxt_fsm == S_DONE) && w_nxt_err;
            round  <= w_nxt_round;
        end
    end

endmodule

// File: tb/tb_sort_step_sequencer.sv
// Testbench for sort_step_sequencer: drives two instances (GAP_CYCLES=1 and
// GAP_CYCLES=3) from shared stimulus and checks cycle-by-cycle against an
// expected trace built from the step schedule.
module tb_sort_step_sequencer;

    localparam int TIMEOUT = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic sort_done = 1'b0;

    logic       start1, busy1, done1, err1;
    logic [3:0] seq1;
    logic [2:0] st1, rnd1;
    logic       start3, busy3, done3, err3;
    logic [3:0] seq3;
    logic [2:0] st3, rnd3;

    always #5 clk = ~clk;

    sort_step_sequencer #(.ROUNDS(8), .GAP_CYCLES(1), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .sort_done(sort_done),
        .start(start1), .seq_no(seq1), .state(st1), .busy(busy1),
        .done(done1), .err(err1), .round(rnd1)
    );

    sort_step_sequencer #(.ROUNDS(8), .GAP_CYCLES(3), .TIMEOUT(TIMEOUT)) dut3 (
        .clk(clk), .rst(rst), .req(req), .sort_done(sort_done),
        .start(start3), .seq_no(seq3), .state(st3), .busy(busy3),
        .done(done3), .err(err3), .round(rnd3)
    );

    typedef struct packed {
        logic       start;
        logic [2:0] st;
        logic [3:0] seq;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] rnd;
    } out_t;

    typedef struct {
        int   gap_sel;   // 0: GAP_CYCLES=1 instance, 1: GAP_CYCLES=3 instance
        int   d;         // WAIT cycle index in which sort_done is raised
        int   exp_done;  // cycle of the done pulse (req sampled at edge 0)
        logic exp_err;
    } vec_t;

    int n_checks = 0;
    int n_err = 0;

    out_t exp_q[$];
    logic sd_q[$];

    function automatic out_t mk(logic s, logic [2:0] st, int seq, logic b,
                                logic dn, logic e, int r);
        out_t o;
        o.start = s; o.st = st; o.seq = 4'(seq); o.busy = b;
        o.done = dn; o.err = e; o.rnd = 3'(r);
        return o;
    endfunction

    function automatic out_t act(input int sel);
        if (sel == 0) return '{start1, st1, seq1, busy1, done1, err1, rnd1};
        return '{start3, st3, seq3, busy3, done3, err3, rnd3};
    endfunction

    // Expected outputs for cycles 1.. of one sort, from the schedule rules.
    function automatic void build(input int gap, input int d, input bit strays);
        exp_q.delete();
        sd_q.delete();
        exp_q.push_back(mk(1, 3'b000, 0, 1, 0, 0, 0));
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 3'b001, 4*k, 1, 0, 0, r));
            for (int g = 0; g < gap; g++) exp_q.push_back(mk(0, 3'b000, 12, 1, 0, 0, r));
            for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 3'b010, 4*k+2, 1, 0, 0, r));
            for (int g = 0; g < gap; g++) exp_q.push_back(mk(0, 3'b000, 10, 1, 0, 0, r));
        end
        exp_q.push_back(mk(0, 3'b101, 0, 1, 0, 0, 7));
        for (int i = 0; i < exp_q.size(); i++)
            sd_q.push_back(strays && exp_q[i].st != 3'b000 && ($urandom % 6 == 0));
        for (int w = 0; w < 64; w++) begin
            exp_q.push_back(mk(0, 3'b000, 0, 1, 0, 0, 7));
            sd_q.push_back(w == d);
            if (w == d) begin
                exp_q.push_back(mk(0, 3'b000, 0, 1, 1, 0, 7));
                break;
            end
            if (w == TIMEOUT - 1) begin
                exp_q.push_back(mk(0, 3'b000, 0, 1, 1, 1, 7));
                break;
            end
        end
        sd_q.push_back(1'b0);
        exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0));
        sd_q.push_back(1'b0);
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, a, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        sort_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Pulses (or holds) req so it is sampled at edge 0, then compares the
    // selected instance against exp_q for cycles 1..stop_at.
    task automatic run_seq(input int sel, input int stop_at, input bit hold,
                           output int done_c, output logic done_e, output int fin_c);
        out_t a;
        done_c = -1;
        done_e = 1'b0;
        fin_c  = -1;
        @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk);
        #1 if (!hold) req = 1'b0;
        for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
            @(negedge clk);
            a = act(sel);
            chk("trace", i + 1, 32'(a), 32'(exp_q[i]));
            if (a.done && done_c < 0) begin
                done_c = i + 1;
                done_e = a.err;
            end
            if (a.st == 3'b101 && fin_c < 0) fin_c = i + 1;
            sort_done = sd_q[i];
            @(posedge clk);
        end
        sort_done = 1'b0;
    endtask

    vec_t tbl[6];
    int   dc, fc;
    logic de;

    initial begin
        tbl[0] = '{0, 1, 77, 1'b0};    // nominal sorter latency
        tbl[1] = '{0, 0, 76, 1'b0};    // sort_done on first WAIT cycle
        tbl[2] = '{0, 6, 82, 1'b0};    // sort_done on the timeout edge: success
        tbl[3] = '{0, 7, 82, 1'b1};    // no sort_done: timeout at FIN+TIMEOUT+1
        tbl[4] = '{0, 20, 82, 1'b1};
        tbl[5] = '{1, 1, 109, 1'b0};   // GAP_CYCLES=3: FIN at 106

        do_reset();
        @(negedge clk);
        chk("reset_g1", 0, 32'(act(0)), 32'(0));
        chk("reset_g3", 0, 32'(act(1)), 32'(0));

        for (int t = 0; t < 6; t++) begin
            do_reset();
            build(tbl[t].gap_sel ? 3 : 1, tbl[t].d, 1'b1);
            run_seq(tbl[t].gap_sel, 1000, 1'b0, dc, de, fc);
            chk("done_cycle", t, 32'(dc), 32'(tbl[t].exp_done));
            chk("done_err", t, 32'(de), 32'(tbl[t].exp_err));
            chk("fin_cycle", t, 32'(fc), 32'(tbl[t].gap_sel ? 106 : 74));
        end

        // Random sorter latencies and stray sort_done pulses, both instances.
        for (int t = 0; t < 4; t++) begin
            int sel;
            sel = t % 2;
            do_reset();
            build(sel ? 3 : 1, $urandom_range(0, 9), 1'b1);
            run_seq(sel, 1000, 1'b0, dc, de, fc);
        end

        // Reset in cycle 30 (mid PH_B), then a clean rerun.
        do_reset();
        build(1, 1, 1'b0);
        run_seq(0, 30, 1'b0, dc, de, fc);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out", 31, 32'(act(0)), 32'(0));
        rst = 1'b0;
        run_seq(0, 1000, 1'b0, dc, de, fc);
        chk("midrst_rerun_done", 0, 32'(dc), 32'(77));

        // req held high: back-to-back sorts, LOAD right after one IDLE cycle.
        do_reset();
        build(1, 1, 1'b1);
        run_seq(0, 1000, 1'b1, dc, de, fc);
        @(negedge clk);
        chk("held_reload", 79, 32'({start1, busy1, st1}), 32'({1'b1, 1'b1, 3'b000}));
        req = 1'b0;
        sort_done = 1'b0;
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (st1 == 3'b101) begin
                    sort_done = 1'b1;
                end
                if (done1) break;
            end
            sort_done = 1'b0;
            chk("held_second_done", k, 32'(k < 200), 32'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sort_step_sequencer.md
Name: sort_step_sequencer

Overview:
- Controller for the 16-entry windowed sorting block, which sorts 4 elements at a time at a given offset.
- On a request, it issues the load strobe, then a fixed odd/even schedule of 4-wide window operations (seq_no/state), then the finish code.
- It then waits for the sorter's done_sorting and returns a one-cycle done to the requester.
- It sits between the requesting engine and the sorting datapath. All outputs are registered.

Parameters:
- ROUNDS, 8, number of A+B round pairs; 8 fully sorts 16 entries.
- GAP_CYCLES, 1, idle cycles (state=000) after each phase, so writeback completes before overlapping windows read; legal range 1..3.
- TIMEOUT, 7, max cycles to wait for sort_done after FIN before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  1  start a sort; sampled only in IDLE
- sort_done  in  1  sorter done_sorting
- start  out  1  load strobe to sorter
- seq_no  out  4  window base offset to sorter
- state  out  3  sorter step code: 000 idle/gap, 001 phase A, 010 phase B, 101 finish
- busy  out  1  high from LOAD through DONE inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when a timeout occurred
- round  out  3  current round index, for debug

Behaviour:
- One clock; reset is synchronous and active-high, on clk/rst.
- Reset values: start=0, seq_no=0, state=000, busy=0, done=0, err=0, round=0; FSM goes to IDLE.
- Reset mid-operation aborts immediately: no done pulse, and the state output returns to 000 on the next cycle.
- FSM: IDLE -> LOAD -> PH_A -> GAP_A -> PH_B -> GAP_B -> (PH_A | FIN) -> WAIT -> DONE -> IDLE.
- IDLE: all outputs 0. req=1 at an edge moves to LOAD. req is level-sampled; req held high re-triggers only after returning to IDLE.
- LOAD: one cycle. start=1, state=000, seq_no=0, busy=1.
- PH_A: 4 cycles, state=001, seq_no = 0, 4, 8, 12 in order.
- PH_B: 3 cycles, state=010, seq_no = 2, 6, 10 in order.
- seq_no never exceeds 12; no wrap-around is permitted. Window +3 must stay at or below 15.
- GAP_A / GAP_B: GAP_CYCLES cycles each. state=000, seq_no holds its last value.
- After GAP_B: if round == ROUNDS-1, go to FIN; otherwise increment round and go to PH_A.
- FIN: one cycle, state=101, seq_no=0.
- WAIT: state=000. Counter starts at 0 on entry.
  - sort_done=1 goes to DONE.
  - If the counter reaches TIMEOUT with no sort_done, go to DONE with the error flag set.
  - sort_done high on the same edge as the timeout counts as success, not error.
- DONE: one cycle, done=1, err = error flag, busy=1. Next cycle goes to IDLE, with busy=0 and round=0.
- sort_done outside WAIT is ignored.
- Latency, GAP_CYCLES=1, ROUNDS=8:
  - req sampled at edge 0.
  - LOAD in cycle 1; round r occupies cycles 2+9r .. 10+9r.
  - FIN in cycle 74.
  - A conforming sorter raises sort_done in cycle 76; done is in cycle 77.
- Round count width: 3 bits, sufficient for ROUNDS up to 8.

Test Plan:
- Reset, then req pulse in cycle 0. Required:
  - start=1 only in cycle 1.
  - state/seq_no trace (001,0)(001,4)(001,8)(001,12)(000,12)(010,2)(010,6)(010,10)(000,10), repeated 8 times.
  - state=101 in cycle 74.
  - Sorter model asserts sort_done in cycle 76; done=1, err=0 in cycle 77 only; busy high cycles 1..77.
- Full system with the sorter and input values 15..0 (descending). After done, the sorted index output equals 15,14,...,0 in entries 0..15. Repeat with a random signed 18-bit set; the result must be nondecreasing.
- sort_done held low in WAIT: done=1 and err=1 exactly TIMEOUT+1 cycles after FIN; IDLE the following cycle.
- rst asserted in cycle 30 (mid PH_B): cycle 31 shows state=000, busy=0, start=0, round=0, and no done. A new req afterwards runs the full 77-cycle sequence.
- req held high continuously: back-to-back sorts, with LOAD one cycle after each IDLE cycle. A stray sort_done pulse during PH_A has no effect.
- GAP_CYCLES=3: each gap is 3 cycles at state=000, and FIN moves to cycle 2+13*8=106.
